// File: rtl/ltl_feeder_pkg.sv
// Shared types for the LTL monitor symbol feeder.
package ltl_feeder_pkg;

  localparam int unsigned SYM_W = 8;

  typedef logic [SYM_W-1:0] symbol_t;

  typedef enum logic [2:0] {
    IDLE,
    RESET,
    ARM,
    STREAM,
    DRAIN
  } feeder_state_e;

endpackage

// File: rtl/ltl_feeder_fifo.sv
// Synchronous FIFO with a registered head word and occupancy count.
// flush has priority over push and pop. Pushes when full and pops when
// empty are ignored.
module ltl_feeder_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  // Qualify requests against flush and occupancy.
  always_comb begin
    full    = (count == CW'(DEPTH));
    empty   = (count == '0);
    do_push = push && !full && !flush;
    do_pop  = pop && !empty && !flush;
  end

  // Storage array; no reset needed on data.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers, occupancy and the registered head word.
  // The head is pre-loaded with the next entry on a pop, or with the
  // incoming word when it becomes the only entry.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (do_pop) begin
        head <= (count == CW'(1)) ? din : mem[rd_ptr + 1'b1];
      end else if (do_push && empty) begin
        head <= din;
      end
    end
  end

endmodule

// File: rtl/ltl_symbol_feeder.sv
// Producer side of the LTL automata monitor symbol interface.
// Buffers proposition vectors, sequences monitor reset so the first
// mon_run cycle coincides with mon_reset deassertion, counts symbols,
// and reports stalls and trace completion.
// Optional: define LTL_FEEDER_REPORT_LATCH_EN to add the report latch
// outputs (first_report, first_report_idx, report_hit).
module ltl_symbol_feeder
  import ltl_feeder_pkg::*;
#(
  parameter int unsigned PROP_W      = 8,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned RST_CYCLES  = 2,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned NUM_REPORTS = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   trace_start,
  input  logic                   trace_end,
  input  logic                   evt_valid,
  output logic                   evt_ready,
  input  logic [PROP_W-1:0]      evt_props,
  output logic                   mon_reset,
  output logic                   mon_run,
  output logic [SYM_W-1:0]       mon_symbols,
  input  logic [NUM_REPORTS-1:0] mon_reports,
  output logic [CNT_W-1:0]       sym_count,
  output logic                   stall,
  output logic                   done
`ifdef LTL_FEEDER_REPORT_LATCH_EN
  ,
  output logic [NUM_REPORTS-1:0] first_report,
  output logic [CNT_W-1:0]       first_report_idx,
  output logic                   report_hit
`endif
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  feeder_state_e     state;
  logic [RCW-1:0]    rst_cnt;
  logic              te_seen;
  logic [PROP_W-1:0] fifo_head;
  logic [AW:0]       fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              streaming;
  logic              push;
  logic              pop;
  symbol_t           head_sym;
  symbol_t           last_sym;
  logic [CNT_W-1:0]  cnt_inc;

  ltl_feeder_fifo #(
    .WIDTH (PROP_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (trace_start),
    .push    (push),
    .din     (evt_props),
    .pop     (pop),
    .head    (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Handshake and monitor-side outputs, derived from registered state only.
  always_comb begin
    streaming   = (state == STREAM) || (state == DRAIN);
    evt_ready   = ((state == ARM) || (state == STREAM)) && !fifo_full && !te_seen;
    push        = evt_valid && evt_ready && !trace_start;
    pop         = streaming && !fifo_empty;
    mon_run     = pop;
    mon_reset   = !streaming;
    head_sym    = '0;
    head_sym[PROP_W-1:0] = fifo_head;
    mon_symbols = pop ? head_sym : last_sym;
    stall       = (state == STREAM) && fifo_empty && !te_seen;
    cnt_inc     = (sym_count == '1) ? sym_count : sym_count + 1'b1;
  end

  // Trace sequencing FSM; trace_start aborts from any state.
  // A trace_end that arrives with a push in ARM is only remembered, so the
  // pushed event is still streamed before done.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      rst_cnt <= '0;
      te_seen <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (trace_start) begin
        state   <= RESET;
        rst_cnt <= RCW'(RST_CYCLES - 1);
        te_seen <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          RESET: begin
            if (rst_cnt == '0) begin
              state <= ARM;
            end else begin
              rst_cnt <= rst_cnt - 1'b1;
            end
          end
          ARM: begin
            if (trace_end) begin
              te_seen <= 1'b1;
            end
            if (!fifo_empty) begin
              state <= STREAM;
            end else if ((trace_end || te_seen) && !push) begin
              state   <= IDLE;
              done    <= 1'b1;
              te_seen <= 1'b0;
            end
          end
          STREAM: begin
            if (trace_end || te_seen) begin
              te_seen <= 1'b1;
              state   <= DRAIN;
            end
          end
          DRAIN: begin
            if (fifo_empty) begin
              state   <= IDLE;
              done    <= 1'b1;
              te_seen <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Saturating count of delivered symbols, cleared at each trace start.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sym_count <= '0;
    end else if (trace_start) begin
      sym_count <= '0;
    end else if (pop) begin
      sym_count <= cnt_inc;
    end
  end

  // Last delivered symbol, held on mon_symbols while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_sym <= '0;
    end else if (pop) begin
      last_sym <= head_sym;
    end
  end

`ifdef LTL_FEEDER_REPORT_LATCH_EN
  // Sticky capture of monitor reports and the index of the first hit.
  always_ff @(posedge clk) begin
    if (!reset_n || trace_start) begin
      first_report     <= '0;
      first_report_idx <= '0;
      report_hit       <= 1'b0;
    end else if (mon_run) begin
      first_report <= first_report | mon_reports;
      if (!report_hit && (|mon_reports)) begin
        report_hit       <= 1'b1;
        first_report_idx <= cnt_inc;
      end
    end
  end
`else
  logic unused_reports;
  assign unused_reports = ^mon_reports;
`endif

endmodule

// File: tb/tb_ltl_symbol_feeder.sv
// Directed testbench for ltl_symbol_feeder and its FIFO.
module tb_ltl_symbol_feeder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        trace_start;
  logic        trace_end;
  logic        evt_valid;
  logic [7:0]  evt_props;
  logic [3:0]  mon_reports;

  logic        evt_ready, mon_reset, mon_run, stall, done;
  logic [7:0]  mon_symbols;
  logic [15:0] sym_count;

  logic        s_evt_ready, s_mon_reset, s_mon_run, s_stall, s_done;
  logic [7:0]  s_mon_symbols;
  logic [1:0]  s_sym_count;

  logic        f_flush, f_push, f_pop, f_full, f_empty;
  logic [7:0]  f_din, f_head;
  logic [3:0]  f_count;

`ifdef LTL_FEEDER_REPORT_LATCH_EN
  logic [3:0]  first_report, s_first_report;
  logic [15:0] first_report_idx;
  logic [1:0]  s_first_report_idx;
  logic        report_hit, s_report_hit;
`endif

  int n_total = 0;
  int n_bad   = 0;
  int runs    = 0;
  bit rep_mode = 1'b0;

  always #5 clk = ~clk;

  ltl_symbol_feeder #(
    .PROP_W(8), .DEPTH(8), .RST_CYCLES(2), .CNT_W(16), .NUM_REPORTS(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .trace_start(trace_start), .trace_end(trace_end),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_props(evt_props),
    .mon_reset(mon_reset), .mon_run(mon_run), .mon_symbols(mon_symbols),
    .mon_reports(mon_reports), .sym_count(sym_count), .stall(stall), .done(done)
`ifdef LTL_FEEDER_REPORT_LATCH_EN
    , .first_report(first_report), .first_report_idx(first_report_idx),
    .report_hit(report_hit)
`endif
  );

  ltl_symbol_feeder #(
    .PROP_W(8), .DEPTH(8), .RST_CYCLES(2), .CNT_W(2), .NUM_REPORTS(4)
  ) dut_sat (
    .clk(clk), .reset_n(reset_n), .trace_start(trace_start), .trace_end(trace_end),
    .evt_valid(evt_valid), .evt_ready(s_evt_ready), .evt_props(evt_props),
    .mon_reset(s_mon_reset), .mon_run(s_mon_run), .mon_symbols(s_mon_symbols),
    .mon_reports(mon_reports), .sym_count(s_sym_count), .stall(s_stall), .done(s_done)
`ifdef LTL_FEEDER_REPORT_LATCH_EN
    , .first_report(s_first_report), .first_report_idx(s_first_report_idx),
    .report_hit(s_report_hit)
`endif
  );

  ltl_feeder_fifo #(.WIDTH(8), .DEPTH(8)) u_fifo (
    .clk(clk), .reset_n(reset_n), .flush(f_flush), .push(f_push), .din(f_din),
    .pop(f_pop), .head(f_head), .count(f_count), .full(f_full), .empty(f_empty)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle and sample 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (rep_mode) begin
      if (mon_run) runs++;
      mon_reports = (mon_run && runs == 3) ? 4'b0100 : 4'b0000;
    end
  endtask

  // Pulse trace_start and wait out RESET; ends with the feeder in ARM.
  task automatic start_trace();
    trace_start = 1'b1;
    step();
    trace_start = 1'b0;
    step();
    step();
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 20 && done !== 1'b1; i++) step();
    check(tag, 32'(done), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; trace_start = 1'b0; trace_end = 1'b0;
    evt_valid = 1'b0; evt_props = 8'h00; mon_reports = 4'b0000;
    f_flush = 1'b0; f_push = 1'b0; f_pop = 1'b0; f_din = 8'h00;
    step();
    step();
    check("rst_mon_reset", 32'(mon_reset), 32'd1);
    check("rst_mon_run", 32'(mon_run), 32'd0);
    check("rst_symbols", 32'(mon_symbols), 32'h00);
    check("rst_count", 32'(sym_count), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(evt_ready), 32'd0);
    reset_n = 1'b1;
    step();

    // Basic stream 0x05, 0x2A, 0x80
    trace_start = 1'b1;
    step();
    check("basic_reset1", 32'(mon_reset), 32'd1);
    check("basic_ready_reset", 32'(evt_ready), 32'd0);
    trace_start = 1'b0;
    step();
    check("basic_reset2", 32'(mon_reset), 32'd1);
    check("basic_ready_reset2", 32'(evt_ready), 32'd0);
    step();
    check("basic_arm_ready", 32'(evt_ready), 32'd1);
    check("basic_arm_reset", 32'(mon_reset), 32'd1);
    evt_valid = 1'b1; evt_props = 8'h05;
    step();
    check("basic_arm_norun", 32'(mon_run), 32'd0);
    check("basic_arm_reset_b", 32'(mon_reset), 32'd1);
    evt_props = 8'h2A;
    step();
    check("basic_first_run", 32'(mon_run), 32'd1);
    check("basic_first_reset_low", 32'(mon_reset), 32'd0);
    check("basic_sym0", 32'(mon_symbols), 32'h05);
    evt_props = 8'h80;
    step();
    check("basic_sym1", 32'(mon_symbols), 32'h2A);
    check("basic_cnt1", 32'(sym_count), 32'd1);
    evt_valid = 1'b0; trace_end = 1'b1;
    step();
    trace_end = 1'b0;
    check("basic_sym2", 32'(mon_symbols), 32'h80);
    check("basic_ready_drain", 32'(evt_ready), 32'd0);
    step();
    check("basic_run_off", 32'(mon_run), 32'd0);
    check("basic_sym_hold", 32'(mon_symbols), 32'h80);
    check("basic_done_early", 32'(done), 32'd0);
    check("basic_stall_drain", 32'(stall), 32'd0);
    step();
    check("basic_done", 32'(done), 32'd1);
    check("basic_count", 32'(sym_count), 32'd3);
    step();
    check("basic_done_pulse", 32'(done), 32'd0);
    check("basic_count_hold", 32'(sym_count), 32'd3);

    // Gap stall: 0x10, three empty cycles, 0x11
    start_trace();
    evt_valid = 1'b1; evt_props = 8'h10;
    step();
    evt_valid = 1'b0;
    step();
    check("gap_first", 32'(mon_symbols), 32'h10);
    check("gap_cnt0", 32'(sym_count), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("gap_stall", 32'(stall), 32'd1);
      check("gap_run", 32'(mon_run), 32'd0);
      check("gap_hold", 32'(mon_symbols), 32'h10);
      check("gap_cnt1", 32'(sym_count), 32'd1);
    end
    evt_valid = 1'b1; evt_props = 8'h11;
    step();
    evt_valid = 1'b0;
    check("gap_second", 32'(mon_symbols), 32'h11);
    check("gap_second_run", 32'(mon_run), 32'd1);
    check("gap_second_stall", 32'(stall), 32'd0);
    trace_end = 1'b1;
    step();
    trace_end = 1'b0;
    check("gap_cnt2", 32'(sym_count), 32'd2);
    step();
    check("gap_done", 32'(done), 32'd1);

    // Abort after 4 of 6 symbols, then restart
    start_trace();
    for (int i = 0; i < 6; i++) begin
      evt_valid = 1'b1; evt_props = 8'(8'h31 + i);
      step();
    end
    evt_valid = 1'b0;
    check("abort_cnt4", 32'(sym_count), 32'd4);
    check("abort_head", 32'(mon_symbols), 32'h35);
    trace_start = 1'b1;
    step();
    trace_start = 1'b0;
    check("abort_cnt0", 32'(sym_count), 32'd0);
    check("abort_mon_reset", 32'(mon_reset), 32'd1);
    check("abort_run", 32'(mon_run), 32'd0);
    step();
    step();
    evt_valid = 1'b1; evt_props = 8'h77;
    step();
    evt_valid = 1'b0;
    check("restart_arm_reset", 32'(mon_reset), 32'd1);
    check("restart_arm_run", 32'(mon_run), 32'd0);
    step();
    check("restart_reset_low", 32'(mon_reset), 32'd0);
    check("restart_run", 32'(mon_run), 32'd1);
    check("restart_sym", 32'(mon_symbols), 32'h77);
    trace_end = 1'b1;
    step();
    trace_end = 1'b0;
    step();
    check("restart_done", 32'(done), 32'd1);
    check("restart_cnt", 32'(sym_count), 32'd1);

    // trace_end in ARM with empty FIFO
    start_trace();
    trace_end = 1'b1;
    step();
    trace_end = 1'b0;
    check("arm_end_done", 32'(done), 32'd1);
    check("arm_end_cnt", 32'(sym_count), 32'd0);
    check("arm_end_reset", 32'(mon_reset), 32'd1);
    step();
    check("arm_end_pulse", 32'(done), 32'd0);

    // Five symbols, last pushed together with trace_end
    start_trace();
    for (int i = 0; i < 5; i++) begin
      evt_valid = 1'b1; evt_props = 8'(8'h40 + i);
      trace_end = (i == 4);
      step();
    end
    evt_valid = 1'b0; trace_end = 1'b0;
    wait_done("sat_done");
    check("sat_full_cnt", 32'(sym_count), 32'd5);
    check("sat_cnt", 32'(s_sym_count), 32'd3);
    check("sat_s_done", 32'(s_done), 32'd1);
    check("sat_s_sym", 32'(s_mon_symbols), 32'h44);
    check("sat_s_stall", 32'(s_stall), 32'd0);
    check("sat_s_reset", 32'(s_mon_reset), 32'd1);
    check("sat_s_ready", 32'(s_evt_ready), 32'd0);
    check("sat_s_run", 32'(s_mon_run), 32'd0);

`ifdef LTL_FEEDER_REPORT_LATCH_EN
    // Report on the 3rd symbol
    rep_mode = 1'b1; runs = 0;
    start_trace();
    for (int i = 0; i < 3; i++) begin
      evt_valid = 1'b1; evt_props = 8'(8'h60 + i);
      step();
    end
    evt_valid = 1'b0; trace_end = 1'b1;
    step();
    trace_end = 1'b0;
    wait_done("rep_done");
    check("rep_first", 32'(first_report), 32'h4);
    check("rep_idx", 32'(first_report_idx), 32'd3);
    check("rep_hit", 32'(report_hit), 32'd1);
    rep_mode = 1'b0; mon_reports = 4'b0000;
    trace_start = 1'b1;
    step();
    trace_start = 1'b0;
    check("rep_clr_first", 32'(first_report), 32'h0);
    check("rep_clr_idx", 32'(first_report_idx), 32'd0);
    check("rep_clr_hit", 32'(report_hit), 32'd0);
    step();
    step();
    trace_end = 1'b1;
    step();
    trace_end = 1'b0;
    step();
`endif

    // FIFO backpressure: nine pushes into eight entries, no pops
    for (int i = 0; i < 9; i++) begin
      f_din = 8'(8'hA0 + i);
      if (i < 8) begin
        check("fifo_not_full", 32'(f_full), 32'd0);
      end else begin
        check("fifo_full", 32'(f_full), 32'd1);
        check("fifo_count8", 32'(f_count), 32'd8);
      end
      f_push = !f_full;
      step();
      f_push = 1'b0;
    end
    check("fifo_count_after", 32'(f_count), 32'd8);
    for (int k = 0; k < 8; k++) begin
      check("fifo_order", 32'(f_head), 32'(8'hA0 + k));
      f_pop = 1'b1;
      step();
      f_pop = 1'b0;
    end
    check("fifo_empty", 32'(f_empty), 32'd1);
    f_push = 1'b1; f_din = 8'h5A;
    step();
    f_flush = 1'b1; f_din = 8'h5B;
    step();
    f_flush = 1'b0; f_push = 1'b0;
    check("fifo_flush", 32'(f_count), 32'd0);
    f_push = 1'b1; f_din = 8'h3C;
    step();
    check("fifo_head_new", 32'(f_head), 32'h3C);
    f_din = 8'h3D; f_pop = 1'b1;
    step();
    f_push = 1'b0; f_pop = 1'b0;
    check("fifo_pushpop_cnt", 32'(f_count), 32'd1);
    check("fifo_pushpop_head", 32'(f_head), 32'h3D);

    // Mid-operation reset
    reset_n = 1'b0;
    step();
    check("midrst_cnt", 32'(sym_count), 32'd0);
    check("midrst_fifo", 32'(f_count), 32'd0);
    check("midrst_sym", 32'(mon_symbols), 32'h00);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ltl_symbol_feeder.md
Name: ltl_symbol_feeder

Overview:
- Producer side of the LTL automata monitor symbol interface: buffers per-retirement proposition vectors from the core trace and drives symbols/run/reset into an Automata_* monitor instance.
- Sequences monitor reset so the monitor's start-of-data cycle coincides exactly with the first real symbol of each trace.
- Counts delivered symbols, flags stream stalls and reports trace completion.

Parameters:
- PROP_W, 8, proposition bits per event; 1..8, zero-extended into the 8-bit symbol.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- RST_CYCLES, 2, minimum cycles mon_reset is held high; at least 1.
- CNT_W, 16, symbol counter width; counter saturates.
- NUM_REPORTS, 4, width of the monitor report vector.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset_n  in  1  synchronous, active-low reset.
- trace_start  in  1  pulse; begin new trace (flush and re-arm).
- trace_end  in  1  pulse; no more events for current trace.
- evt_valid  in  1  event handshake valid.
- evt_ready  out  1  event handshake ready.
- evt_props  in  PROP_W  proposition vector.
- mon_reset  out  1  active-high reset to monitor.
- mon_run  out  1  symbol-valid strobe to monitor.
- mon_symbols  out  8  symbol to monitor.
- mon_reports  in  NUM_REPORTS  monitor report outputs.
- sym_count  out  CNT_W  symbols delivered in current trace.
- stall  out  1  FIFO empty while streaming and trace not ended.
- done  out  1  one-cycle pulse when trace fully delivered.

Behaviour:
- Reset (reset_n=0 at posedge):
  - state=IDLE, FIFO empty.
  - mon_reset=1, mon_run=0, mon_symbols=0, sym_count=0, stall=0, done=0, evt_ready=0.
- Event handshake:
  - Push when evt_valid&&evt_ready.
  - evt_ready=1 iff state is ARM or STREAM, FIFO not full, and trace_end not yet seen.
  - evt_props is held until accepted.
- Interface control: mon_reset is 1 in IDLE, RESET and ARM, and 0 in STREAM and DRAIN.
- States:
  - IDLE: trace_start -> RESET. Load the reset counter with RST_CYCLES-1 and flush the FIFO.
  - RESET: mon_reset=1; counter decrements each cycle; at 0 -> ARM.
  - ARM: mon_reset=1, events accepted. When the FIFO is non-empty (registered occupancy) -> STREAM.
  - STREAM: the first STREAM cycle deasserts mon_reset, asserts mon_run and presents the FIFO head. This is the monitor's start_of_data cycle.
    - Each cycle with the FIFO non-empty: pop, mon_run=1, mon_symbols={zeros, head}, sym_count+1 (saturate at all-ones).
    - FIFO empty: mon_run=0, mon_symbols holds its last value, stall=1 unless trace_end has been seen.
    - trace_end seen -> DRAIN.
  - DRAIN: continue popping. When the FIFO is empty, pulse done for one cycle -> IDLE.
    - sym_count holds its value until the next trace_start.
- Combinational path: mon_symbols/mon_run come from registered FIFO head and occupancy only; no combinational path from evt_* to mon_*.
- Simultaneous events:
  - Push and pop in the same cycle leave occupancy unchanged; a full FIFO with a pop still refuses the push that cycle, because evt_ready uses registered state.
  - trace_end with a push in the same cycle: the push is accepted, and the event is the trace's last.
  - trace_end in ARM with the FIFO empty: go to IDLE, pulse done, sym_count=0.
  - trace_start in any non-IDLE state (mid-trace): abort, flush FIFO, sym_count=0, mon_run=0, mon_reset=1 the next cycle -> RESET. trace_start has priority over trace_end and over push.
- Reset mid-operation: identical to the reset values above, on the next posedge.

Optional Feature:
- Macro: LTL_FEEDER_REPORT_LATCH_EN.
- With the macro, the block adds these outputs:
  - first_report (NUM_REPORTS bits): sticky OR of mon_reports sampled in cycles with mon_run=1.
  - first_report_idx (CNT_W bits): sym_count value of the first symbol in which any report bit was set.
  - report_hit (1 bit).
  - All three clear on reset_n=0 and on trace_start.
- Without the macro: mon_reports is unused, and these outputs and their registers do not exist.

Decomposition:
- Package ltl_feeder_pkg:
  - feeder_state_e enum (IDLE, RESET, ARM, STREAM, DRAIN).
  - SYM_W=8 constant.
  - symbol_t typedef (logic [SYM_W-1:0]).
- Sub-module ltl_feeder_fifo: synchronous FIFO, DEPTH entries, registered head, count output, and a flush input with priority over push and pop.

Test Plan:
- Basic stream: trace_start, then push 0x05,0x2A,0x80, then trace_end.
  - mon_reset high for 2 cycles plus ARM.
  - First mon_run cycle has mon_reset=0 and symbol 0x05, then 0x2A, then 0x80.
  - done pulses once; sym_count=3.
- Backpressure: DEPTH=8, no pops (events pushed in ARM before transition is suppressed by holding STREAM via forced stall model).
  - Push 9 events while the monitor side is throttled.
  - evt_ready=0 at 8 entries; no event lost or duplicated; order preserved.
- Gap stall: push 0x10, wait 3 idle cycles, push 0x11.
  - mon_run=0 and stall=1 for the gap cycles.
  - mon_symbols holds 0x10; sym_count goes 1 -> 2.
- Abort: trace_start after 4 of 6 symbols.
  - FIFO flushed, sym_count=0, mon_reset=1 on the next cycle.
  - Restarted trace's first symbol coincides with mon_reset deassert.
- Edge cases:
  - trace_end in ARM with an empty FIFO: done with sym_count=0.
  - CNT_W=2 stream of 5 symbols: sym_count saturates at 3.
- With LTL_FEEDER_REPORT_LATCH_EN: drive mon_reports=4'b0100 during the 3rd symbol.
  - first_report=4'b0100, first_report_idx=3, report_hit=1.
  - All three cleared by the next trace_start.
